// File: rtl/ip_flit_sink_if.sv
// Flit ejection link between a switch local output port and its IP sink.
// The switch drives data_i/in_w; the sink answers with a registered out_r.
interface ip_flit_sink_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 4
) ();

  // {tail, addr, payload}
  logic [DATA_SIZE+ADDR_SIZE:0] data_i;
  logic                         in_w;
  logic                         out_r;

  modport master (
    output data_i,
    output in_w,
    input  out_r
  );

  modport slave (
    input  data_i,
    input  in_w,
    output out_r
  );

endinterface

// File: rtl/ip_flit_sink.sv
// Traffic sink on a switch local port: reassembles packets, checks flit
// addresses and packet length, keeps saturating statistics and injects a
// periodic backpressure pattern on out_r.
module ip_flit_sink #(
  parameter int unsigned DATA_SIZE     = 8,
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned ADDR          = 0,
  parameter int unsigned MAX_PACK_LEN  = 8,
  parameter int unsigned PACKS_TO_RECV = 16,
  parameter int unsigned STALL_PERIOD  = 0,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk,
  input  logic               a_rst,
  ip_flit_sink_if.slave      slv,
  output logic [CNT_W-1:0]   flit_cnt,
  output logic [CNT_W-1:0]   pack_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [7:0]         last_len,
  output logic               err,
  output logic               done
);

  localparam int unsigned    ScW    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int unsigned    ScMax  = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  state_e                  r_state, w_state_next;
  logic [ScW-1:0]          r_sc, w_sc_next;
  logic                    r_out_r, w_out_r_next;
  logic [7:0]              r_len, w_len_cur;
  logic                    r_perr, w_perr_cur;
  logic [CNT_W-1:0]        r_flit_cnt, r_pack_cnt, r_err_cnt;
  logic [7:0]              r_last_len;
  logic                    r_err, r_done;

  logic                    w_accept;
  logic                    w_tail;
  logic [ADDR_SIZE-1:0]    w_addr;
  logic                    w_addr_bad;

  // Saturating +1 shared by all statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  assign w_accept   = slv.in_w & r_out_r;
  assign w_tail     = slv.data_i[DATA_SIZE+ADDR_SIZE];
  assign w_addr     = slv.data_i[DATA_SIZE+ADDR_SIZE-1:DATA_SIZE];
  assign w_addr_bad = (w_addr != ADDR_SIZE'(ADDR));

  assign slv.out_r = r_out_r;
  assign flit_cnt  = r_flit_cnt;
  assign pack_cnt  = r_pack_cnt;
  assign err_cnt   = r_err_cnt;
  assign last_len  = r_last_len;
  assign err       = r_err;
  assign done      = r_done;

  // Stall pattern: out_r drops in the cycle where the counter sits at ScMax.
  always_comb begin
    w_sc_next    = (r_sc == ScW'(ScMax)) ? '0 : r_sc + ScW'(1);
    w_out_r_next = (STALL_PERIOD == 0) ? 1'b1 : (w_sc_next != ScW'(ScMax));
  end

  // Stall counter and registered ready; ready stays low while in reset.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_sc    <= '0;
      r_out_r <= 1'b0;
    end else begin
      r_sc    <= w_sc_next;
      r_out_r <= w_out_r_next;
    end
  end

  // Next state plus the length/error view of the packet including this flit.
  always_comb begin
    w_state_next = r_state;
    w_len_cur    = 8'd1;
    w_perr_cur   = 1'b0;
    if (r_state == StBody) begin
      w_len_cur  = (r_len == 8'hFF) ? 8'hFF : r_len + 8'd1;
      w_perr_cur = r_perr;
    end
    w_perr_cur = w_perr_cur | w_addr_bad | (32'(w_len_cur) > MAX_PACK_LEN);
    if (w_accept) begin
      unique case (r_state)
        StIdle:  w_state_next = w_tail ? StIdle : StBody;
        StBody:  w_state_next = w_tail ? StIdle : StBody;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Per-packet tracking and statistics, all updated on the accepting edge.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_len      <= '0;
      r_perr     <= 1'b0;
      r_flit_cnt <= '0;
      r_pack_cnt <= '0;
      r_err_cnt  <= '0;
      r_last_len <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_flit_cnt <= sat_inc(r_flit_cnt);
      if (w_tail) begin
        r_pack_cnt <= sat_inc(r_pack_cnt);
        r_last_len <= w_len_cur;
        if (w_perr_cur) begin
          r_err_cnt <= sat_inc(r_err_cnt);
          r_err     <= 1'b1;
        end
        r_len  <= '0;
        r_perr <= 1'b0;
      end else begin
        r_len  <= w_len_cur;
        r_perr <= w_perr_cur;
      end
    end
  end

  // Sticky done, one cycle behind the packet counter reaching its target.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_done <= 1'b0;
    end else if ((PACKS_TO_RECV != 0) && (r_pack_cnt >= CNT_W'(PACKS_TO_RECV))) begin
      r_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ip_flit_sink.sv
// Directed bench for ip_flit_sink: a table of flits against one sink (ADDR=3,
// PACKS_TO_RECV=2, no stalls) plus hand sequences for backpressure on a
// second sink (STALL_PERIOD=4) and an asynchronous mid-packet reset.
module tb_ip_flit_sink;

  logic clk = 1'b0;
  logic a_rst;
  always #5 clk = ~clk;

  ip_flit_sink_if #(.DATA_SIZE(8), .ADDR_SIZE(4)) a_if ();
  ip_flit_sink_if #(.DATA_SIZE(8), .ADDR_SIZE(4)) b_if ();

  logic [31:0] a_flit_cnt, a_pack_cnt, a_err_cnt;
  logic [7:0]  a_last_len;
  logic        a_err, a_done;
  logic [31:0] b_flit_cnt, b_pack_cnt, b_err_cnt;
  logic [7:0]  b_last_len;
  logic        b_err, b_done;

  ip_flit_sink #(
    .DATA_SIZE(8), .ADDR_SIZE(4), .ADDR(3), .MAX_PACK_LEN(8),
    .PACKS_TO_RECV(2), .STALL_PERIOD(0), .CNT_W(32)
  ) u_dut_a (
    .clk(clk), .a_rst(a_rst), .slv(a_if),
    .flit_cnt(a_flit_cnt), .pack_cnt(a_pack_cnt), .err_cnt(a_err_cnt),
    .last_len(a_last_len), .err(a_err), .done(a_done)
  );

  ip_flit_sink #(
    .DATA_SIZE(8), .ADDR_SIZE(4), .ADDR(0), .MAX_PACK_LEN(8),
    .PACKS_TO_RECV(0), .STALL_PERIOD(4), .CNT_W(32)
  ) u_dut_b (
    .clk(clk), .a_rst(a_rst), .slv(b_if),
    .flit_cnt(b_flit_cnt), .pack_cnt(b_pack_cnt), .err_cnt(b_err_cnt),
    .last_len(b_last_len), .err(b_err), .done(b_done)
  );

  typedef struct {
    logic        v;
    logic        t;
    logic [3:0]  a;
    int unsigned ef;
    int unsigned ep;
    int unsigned ee;
    int unsigned el;
    logic        er;
    logic        edn;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_row(input logic v, input logic t, input logic [3:0] a,
                         input int unsigned ef, input int unsigned ep,
                         input int unsigned ee, input int unsigned el,
                         input logic er, input logic edn);
    vec_t r;
    r.v = v; r.t = t; r.a = a; r.ef = ef; r.ep = ep;
    r.ee = ee; r.el = el; r.er = er; r.edn = edn;
    vq.push_back(r);
  endtask

  task automatic drive_a(input logic v, input logic t, input logic [3:0] a, input logic [7:0] d);
    a_if.in_w   = v;
    a_if.data_i = {t, a, d};
  endtask

  initial begin
    int lows;
    int last_low;

    a_rst = 1'b0;
    drive_a(1'b0, 1'b0, 4'd0, 8'd0);
    b_if.in_w   = 1'b0;
    b_if.data_i = '0;

    // Table: 1-, 4-, 8-flit packets, a 9-flit overlength packet, a good 2-flit
    // packet, an idle cycle, a 4-flit packet with a bad 3rd address, then a
    // good 1-flit packet and a 1-flit packet with a bad address on its tail.
    add_row(1, 1, 3,  1, 1, 0, 1, 0, 0);
    add_row(1, 0, 3,  2, 1, 0, 1, 0, 0);
    add_row(1, 0, 3,  3, 1, 0, 1, 0, 0);
    add_row(1, 0, 3,  4, 1, 0, 1, 0, 0);
    add_row(1, 1, 3,  5, 2, 0, 4, 0, 0);
    add_row(1, 0, 3,  6, 2, 0, 4, 0, 1);
    for (int i = 7; i <= 12; i++) add_row(1, 0, 3, i, 2, 0, 4, 0, 1);
    add_row(1, 1, 3, 13, 3, 0, 8, 0, 1);
    for (int i = 14; i <= 21; i++) add_row(1, 0, 3, i, 3, 0, 8, 0, 1);
    add_row(1, 1, 3, 22, 4, 1, 9, 1, 1);
    add_row(1, 0, 3, 23, 4, 1, 9, 1, 1);
    add_row(1, 1, 3, 24, 5, 1, 2, 1, 1);
    add_row(0, 1, 5, 24, 5, 1, 2, 1, 1);
    add_row(1, 0, 3, 25, 5, 1, 2, 1, 1);
    add_row(1, 0, 3, 26, 5, 1, 2, 1, 1);
    add_row(1, 0, 5, 27, 5, 1, 2, 1, 1);
    add_row(1, 1, 3, 28, 6, 2, 4, 1, 1);
    add_row(1, 1, 3, 29, 7, 2, 1, 1, 1);
    add_row(1, 1, 7, 30, 8, 3, 1, 1, 1);

    // Reset and release.
    repeat (2) @(negedge clk);
    check("out_r in reset", {31'd0, a_if.out_r}, 32'd0);
    a_rst = 1'b1;
    #1;
    check("out_r before first edge", {31'd0, a_if.out_r}, 32'd0);
    @(negedge clk);
    check("out_r after release", {31'd0, a_if.out_r}, 32'd1);
    check("reset flit_cnt", a_flit_cnt, 32'd0);
    check("reset pack_cnt", a_pack_cnt, 32'd0);
    check("reset err_cnt", a_err_cnt, 32'd0);
    check("reset last_len", {24'd0, a_last_len}, 32'd0);
    check("reset err", {31'd0, a_err}, 32'd0);
    check("reset done", {31'd0, a_done}, 32'd0);

    // Table-driven flits on sink A, one per cycle.
    for (int k = 0; k < vq.size(); k++) begin
      drive_a(vq[k].v, vq[k].t, vq[k].a, 8'(k));
      @(negedge clk);
      check($sformatf("row%0d flit_cnt", k), a_flit_cnt, vq[k].ef);
      check($sformatf("row%0d pack_cnt", k), a_pack_cnt, vq[k].ep);
      check($sformatf("row%0d err_cnt", k), a_err_cnt, vq[k].ee);
      check($sformatf("row%0d last_len", k), {24'd0, a_last_len}, vq[k].el);
      check($sformatf("row%0d err", k), {31'd0, a_err}, {31'd0, vq[k].er});
      check($sformatf("row%0d done", k), {31'd0, a_done}, {31'd0, vq[k].edn});
    end
    drive_a(1'b0, 1'b0, 4'd0, 8'd0);

    // Backpressure on sink B: stream of 1-flit packets for 40 cycles.
    @(negedge clk);
    b_if.in_w   = 1'b1;
    b_if.data_i = {1'b1, 4'd0, 8'h5A};
    lows     = 0;
    last_low = -1;
    for (int i = 0; i < 40; i++) begin
      if (!b_if.out_r) begin
        lows++;
        if (last_low >= 0) check("stall gap", 32'(i - last_low), 32'd4);
        last_low = i;
      end
      @(negedge clk);
    end
    b_if.in_w = 1'b0;
    check("stall low count", 32'(lows), 32'd10);
    check("stall flit_cnt", b_flit_cnt, 32'd30);
    check("stall pack_cnt", b_pack_cnt, 32'd30);
    check("stall err_cnt", b_err_cnt, 32'd0);
    check("stall last_len", {24'd0, b_last_len}, 32'd1);

    // Mid-packet asynchronous reset on sink A after flit 2 of 5.
    @(negedge clk);
    drive_a(1'b1, 1'b0, 4'd3, 8'h11);
    @(negedge clk);
    drive_a(1'b1, 1'b0, 4'd3, 8'h22);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 4'd0, 8'd0);
    check("pre-reset flit_cnt", a_flit_cnt, 32'd32);
    #2;
    a_rst = 1'b0;
    #1;
    check("async flit_cnt", a_flit_cnt, 32'd0);
    check("async pack_cnt", a_pack_cnt, 32'd0);
    check("async err_cnt", a_err_cnt, 32'd0);
    check("async last_len", {24'd0, a_last_len}, 32'd0);
    check("async err", {31'd0, a_err}, 32'd0);
    check("async done", {31'd0, a_done}, 32'd0);
    check("async out_r", {31'd0, a_if.out_r}, 32'd0);
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    check("re-release out_r", {31'd0, a_if.out_r}, 32'd1);
    drive_a(1'b1, 1'b0, 4'd3, 8'h33);
    @(negedge clk);
    drive_a(1'b1, 1'b1, 4'd3, 8'h44);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 4'd0, 8'd0);
    check("post-reset pack_cnt", a_pack_cnt, 32'd1);
    check("post-reset last_len", {24'd0, a_last_len}, 32'd2);
    check("post-reset err", {31'd0, a_err}, 32'd0);
    check("post-reset flit_cnt", a_flit_cnt, 32'd2);
    check("post-reset err_cnt", a_err_cnt, 32'd0);
    @(negedge clk);
    check("post-reset done", {31'd0, a_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_flit_sink.md
Name: ip_flit_sink

Overview:
- Traffic-sink endpoint attached to the local (IP) output port of a switch.
- Consumes flits the switch ejects toward its node, reassembles them into packets and checks that every flit is addressed to this node and that packet length stays within bounds.
- Keeps packet, flit and error counters for end-of-test reporting by the NoC bench.
- Injects a programmable backpressure pattern to exercise switch ejection stalls.

Parameters:
- DATA_SIZE, 8, payload bits per flit.
- ADDR_SIZE, 4, destination-address bits per flit.
- ADDR, 0, node address of this sink; every accepted flit must carry it.
- MAX_PACK_LEN, 8, maximum legal packet length in flits (>=1).
- PACKS_TO_RECV, 16, packet count that raises done; 0 means done never asserts.
- STALL_PERIOD, 0, out_r is dropped for 1 cycle every STALL_PERIOD cycles; 0 disables stalls.
- CNT_W, 32, width of all statistics counters.

Ports:
- clk, in, 1, clock.
- a_rst, in, 1, asynchronous active-low reset.
- data_i, in, DATA_SIZE+ADDR_SIZE+1, flit from the switch.
  - bit [DATA_SIZE+ADDR_SIZE] is tail.
  - bits [DATA_SIZE+ADDR_SIZE-1:DATA_SIZE] are addr.
  - bits [DATA_SIZE-1:0] are payload.
- in_w, in, 1, switch presents a valid flit.
- out_r, out, 1, sink ready; a flit transfers on a rising clk edge when in_w && out_r.
- flit_cnt, out, CNT_W, accepted flits.
- pack_cnt, out, CNT_W, completed packets (tail accepted).
- err_cnt, out, CNT_W, packets with at least one error.
- last_len, out, 8, length of the most recently completed packet.
- err, out, 1, sticky: any error seen since reset.
- done, out, 1, sticky: pack_cnt reached PACKS_TO_RECV.

Behaviour:
- Reset (a_rst=0, asynchronous): all counters, last_len, err, done, FSM and stall counter go to 0. out_r is 0 while reset is asserted and goes to 1 on the first clk edge after release. Reset mid-packet discards the partial packet with no count.
- Stall generator: free-running counter sc, 0..STALL_PERIOD-1.
  - out_r = 0 in the cycle where sc==STALL_PERIOD-1, else 1.
  - With STALL_PERIOD=0, out_r is constantly 1 after reset.
  - out_r is registered; it never depends combinationally on in_w.
- FSM states:
  - IDLE: waiting for a head flit. An accepted flit goes to BODY if tail=0. If tail=1 it completes a 1-flit packet and the FSM stays in IDLE.
  - BODY: mid-packet. An accepted flit with tail=1 completes the packet and returns to IDLE. A flit with tail=0 stays in BODY.
  - No flit accepted: state holds.
- Per-packet tracking:
  - len is the flit count including the current flit. The first flit sets len=1; each later flit sets len=len+1, saturating at 255.
  - perr (per-packet error flag) is set if addr != ADDR on any flit, or if len exceeds MAX_PACK_LEN. The length error occurs on flit MAX_PACK_LEN+1.
  - Errored packets are still consumed up to their tail; there is no resynchronisation beyond that.
- Packet completion, on the accepted tail flit:
  - pack_cnt increments.
  - last_len <= len.
  - err_cnt increments if perr (including an error found on the tail flit itself), with at most one increment per packet.
  - err <= 1 if perr.
  - perr and len clear for the next packet.
- flit_cnt increments on every accepted flit.
- All counters saturate at all-ones; there is no wrap.
- done goes to 1 in the cycle after pack_cnt becomes equal to PACKS_TO_RECV, and stays 1. The sink keeps accepting and counting after done.
- No acceptance when in_w=1 and out_r=0: the flit is held by the switch and no state changes.
- data_i is ignored when in_w=0.
- Latency: counters and flags update on the same edge that accepts the flit; they are visible the next cycle. done has one extra cycle of latency.

Test Plan:
- Reset release, STALL_PERIOD=0, idle bus:
  - out_r=1 from the first edge after release.
  - All counters 0; err=0, done=0.
- ADDR=3: send 3 packets of length 1, 4 and 8 (MAX_PACK_LEN=8), all addr=3, back-to-back with in_w held high.
  - flit_cnt=13, pack_cnt=3, last_len=8, err_cnt=0, err=0.
- Packet of length 9 to ADDR=3:
  - err_cnt=1, err=1, last_len=9.
  - A following good 2-flit packet gives pack_cnt+1 with no further err_cnt increment.
- 4-flit packet whose 3rd flit has addr=5:
  - err_cnt=1 (not 2).
  - Packet still completes on its tail; FSM returns to IDLE.
- STALL_PERIOD=4, in_w held high with a stream of 1-flit packets:
  - out_r low exactly every 4th cycle.
  - Exactly 3 flits accepted per 4 cycles; flit_cnt=pack_cnt=30 after 40 cycles.
- PACKS_TO_RECV=2:
  - done=0 after packet 1.
  - done=1 the cycle after packet 2's tail is accepted.
- Reset in mid-packet, asserting a_rst after flit 2 of 5:
  - All outputs return to 0 immediately, asynchronously.
  - After release, a new 2-flit packet gives pack_cnt=1, last_len=2, err=0.
